// File: rtl/fft_input_reorder.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : fft_input_reorder                                          |
// | Description : Ping-pong bit-reversal frame buffer feeding the first      |
// |               radix-2 butterfly stage of a 16-point FFT. Real samples    |
// |               are written at bit-reversed addresses; each completed      |
// |               frame drains as 8 (x_m, x_n) pairs with twiddle index 0.   |
// | Option      : FFT_IN_DC_REMOVE_EN - subtract the per-frame mean from     |
// |               every output sample, saturated to DATA_W bits.             |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module fft_input_reorder #(
    parameter int DATA_W = 12,
    parameter int LOG2_N = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic signed [DATA_W-1:0] in_sample,
    input  logic                     in_valid,
    output logic                     in_ready,
    output logic signed [DATA_W-1:0] out_m_real,
    output logic signed [DATA_W-1:0] out_m_img,
    output logic signed [DATA_W-1:0] out_n_real,
    output logic signed [DATA_W-1:0] out_n_img,
    output logic [LOG2_N-2:0]        out_index,
    output logic [LOG2_N-2:0]        out_pair,
    output logic                     out_last,
    output logic                     out_valid,
    input  logic                     out_ready
);

    localparam int c_frame_len = 1 << LOG2_N;

    // Two frame banks; contents are deliberately not reset.
    logic signed [DATA_W-1:0] r_mem [2][c_frame_len];

    logic                  r_wr_bank;
    logic                  r_rd_bank;
    logic [1:0]            r_bank_full;
    logic [LOG2_N-1:0]     r_wr_cnt;
    logic [LOG2_N-2:0]     r_rd_cnt;
    logic                  r_out_valid;

    logic                  w_wr_en;
    logic                  w_wr_done;
    logic                  w_load;
    logic                  w_rd_done;
    logic [1:0]            w_set_mask;
    logic [1:0]            w_clr_mask;
    logic [LOG2_N-1:0]     w_wr_addr;
    logic [LOG2_N-1:0]     w_addr_m;
    logic [LOG2_N-1:0]     w_addr_n;
    logic signed [DATA_W-1:0] w_m_val;
    logic signed [DATA_W-1:0] w_n_val;

    function automatic logic [LOG2_N-1:0] f_bitrev(input logic [LOG2_N-1:0] a);
        logic [LOG2_N-1:0] r;
        for (int i = 0; i < LOG2_N; i++) begin
            r[i] = a[LOG2_N-1-i];
        end
        return r;
    endfunction

    assign in_ready   = ~r_bank_full[r_wr_bank];
    assign w_wr_en    = in_valid & in_ready;
    assign w_wr_done  = w_wr_en & (&r_wr_cnt);
    assign w_wr_addr  = f_bitrev(r_wr_cnt);

    // The drain side reads naturally ordered adjacent words: pair k is words 2k and 2k+1.
    assign w_load     = r_bank_full[r_rd_bank] & (~r_out_valid | out_ready);
    assign w_rd_done  = w_load & (&r_rd_cnt);
    assign w_addr_m   = {r_rd_cnt, 1'b0};
    assign w_addr_n   = {r_rd_cnt, 1'b1};

    // A set and a clear on the same edge always hit different banks.
    assign w_set_mask = {w_wr_done & r_wr_bank, w_wr_done & ~r_wr_bank};
    assign w_clr_mask = {w_rd_done & r_rd_bank, w_rd_done & ~r_rd_bank};

`ifdef FFT_IN_DC_REMOVE_EN
    localparam int c_sum_w = DATA_W + LOG2_N;

    logic signed [c_sum_w-1:0] r_sum [2];
    logic signed [DATA_W-1:0]  w_mean;

    // Mean of the bank being drained: taking the upper bits is an arithmetic shift.
    assign w_mean = r_sum[r_rd_bank][c_sum_w-1:LOG2_N];

    function automatic logic signed [DATA_W-1:0] f_dc(input logic signed [DATA_W-1:0] s,
                                                      input logic signed [DATA_W-1:0] m);
        logic signed [DATA_W:0] d;
        d = {s[DATA_W-1], s} - {m[DATA_W-1], m};
        if (d[DATA_W] != d[DATA_W-1]) begin
            return {d[DATA_W], {(DATA_W-1){~d[DATA_W]}}};
        end
        return d[DATA_W-1:0];
    endfunction

    // Per-bank running sum, restarted by the first sample of each frame.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sum[0] <= '0;
            r_sum[1] <= '0;
        end else if (w_wr_en) begin
            if (r_wr_cnt == '0) begin
                r_sum[r_wr_bank] <= c_sum_w'(in_sample);
            end else begin
                r_sum[r_wr_bank] <= r_sum[r_wr_bank] + c_sum_w'(in_sample);
            end
        end
    end

    assign w_m_val = f_dc(r_mem[r_rd_bank][w_addr_m], w_mean);
    assign w_n_val = f_dc(r_mem[r_rd_bank][w_addr_n], w_mean);
`else
    assign w_m_val = r_mem[r_rd_bank][w_addr_m];
    assign w_n_val = r_mem[r_rd_bank][w_addr_n];
`endif

    // Store accepted samples at their bit-reversed position.
    always_ff @(posedge clk) begin
        if (w_wr_en) begin
            r_mem[r_wr_bank][w_wr_addr] <= in_sample;
        end
    end

    // Bank pointers, fill/drain counters and full flags.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_bank   <= 1'b0;
            r_rd_bank   <= 1'b0;
            r_bank_full <= 2'b00;
            r_wr_cnt    <= '0;
            r_rd_cnt    <= '0;
        end else begin
            if (w_wr_en) begin
                r_wr_cnt <= r_wr_cnt + 1'b1;
                if (w_wr_done) begin
                    r_wr_bank <= ~r_wr_bank;
                end
            end
            if (w_load) begin
                r_rd_cnt <= r_rd_cnt + 1'b1;
                if (w_rd_done) begin
                    r_rd_bank <= ~r_rd_bank;
                end
            end
            r_bank_full <= (r_bank_full | w_set_mask) & ~w_clr_mask;
        end
    end

    // Output pair register: loads when empty or being consumed, holds under backpressure.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_out_valid <= 1'b0;
            out_m_real  <= '0;
            out_n_real  <= '0;
            out_pair    <= '0;
            out_last    <= 1'b0;
        end else if (w_load) begin
            r_out_valid <= 1'b1;
            out_m_real  <= w_m_val;
            out_n_real  <= w_n_val;
            out_pair    <= r_rd_cnt;
            out_last    <= &r_rd_cnt;
        end else if (out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

    // Real input and stage-1 twiddle make these constant.
    assign out_m_img = '0;
    assign out_n_img = '0;
    assign out_index = '0;
    assign out_valid = r_out_valid;

endmodule
`default_nettype wire

// File: tb/tb_fft_input_reorder.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_fft_input_reorder                                       |
// | Description : Self-checking bench for fft_input_reorder: directed vector |
// |               table, multi-cycle corner sequences and randomized traffic |
// |               against a frame-level reference model.                     |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module tb_fft_input_reorder;

    localparam int DATA_W = 12;
    localparam int LOG2_N = 4;
`ifdef FFT_IN_DC_REMOVE_EN
    localparam int RAMP_MEAN = 7;   // floor(120 / 16)
`else
    localparam int RAMP_MEAN = 0;
`endif

    logic                     clk = 1'b0;
    logic                     rst;
    logic signed [DATA_W-1:0] in_sample;
    logic                     in_valid;
    logic                     in_ready;
    logic signed [DATA_W-1:0] out_m_real, out_m_img, out_n_real, out_n_img;
    logic [LOG2_N-2:0]        out_index, out_pair;
    logic                     out_last, out_valid, out_ready;

    fft_input_reorder #(.DATA_W(DATA_W), .LOG2_N(LOG2_N)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_sample (in_sample),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_m_real(out_m_real),
        .out_m_img (out_m_img),
        .out_n_real(out_n_real),
        .out_n_img (out_n_img),
        .out_index (out_index),
        .out_pair  (out_pair),
        .out_last  (out_last),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input int act, input int req);
        n_checks++;
        if (act == req) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
    endtask

    // ---------------- reference model ----------------
    typedef struct {int m; int n; int p;} pair_t;
    pair_t exp_q[$];
    int    frame_q[$];
    int    pair_src[8] = '{0, 4, 2, 6, 1, 5, 3, 7};   // x_m sample number; x_n is +8
    int    pairs_seen = 0;
    int    last_m, last_n;
    bit    held = 1'b0;
    int    prev_word;

    function automatic int adjust(input int x, input int mean);
`ifdef FFT_IN_DC_REMOVE_EN
        int d;
        d = x - mean;
        if (d > 2047) d = 2047;
        if (d < -2048) d = -2048;
        return d;
`else
        return x + 0 * mean;
`endif
    endfunction

    task automatic close_frame();
        int sum;
        int mean;
        pair_t pr;
        sum = 0;
        foreach (frame_q[i]) sum += frame_q[i];
        mean = sum >>> LOG2_N;
        for (int p = 0; p < 8; p++) begin
            pr.m = adjust(frame_q[pair_src[p]], mean);
            pr.n = adjust(frame_q[pair_src[p] + 8], mean);
            pr.p = p;
            exp_q.push_back(pr);
        end
        frame_q.delete();
    endtask

    // Scoreboard: observes handshakes at the falling edge, ahead of the rising edge that commits them.
    always @(negedge clk) begin
        if (rst) begin
            frame_q.delete();
            exp_q.delete();
            held = 1'b0;
        end else begin
            if (held)
                check("hold_stable", {out_valid, out_last, out_pair, out_m_real, out_n_real}, prev_word);
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_pair", 1, 0);
                end else begin
                    pair_t e;
                    e = exp_q.pop_front();
                    check("pair_m", int'(out_m_real), e.m);
                    check("pair_n", int'(out_n_real), e.n);
                    check("pair_num", int'(out_pair), e.p);
                    check("pair_last", int'(out_last), int'(e.p == 7));
                    check("img_idx_zero", int'(out_m_img) | int'(out_n_img) | int'(out_index), 0);
                end
                pairs_seen++;
                last_m = int'(out_m_real);
                last_n = int'(out_n_real);
            end
            held      = out_valid && !out_ready;
            prev_word = {out_valid, out_last, out_pair, out_m_real, out_n_real};
            if (in_valid && in_ready) begin
                frame_q.push_back(int'(in_sample));
                if (frame_q.size() == 16) close_frame();
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic send(input int v);
        in_sample = DATA_W'(v);
        in_valid  = 1'b1;
        for (int g = 0; g < 300; g++) begin
            @(negedge clk);
            if (in_ready) begin
                @(posedge clk); #1;
                in_valid = 1'b0;
                return;
            end
            @(posedge clk); #1;
        end
        check("send_timeout", 0, 1);
        in_valid = 1'b0;
    endtask

    task automatic wait_drain();
        for (int g = 0; g < 300; g++) begin
            @(negedge clk);
            if (exp_q.size() == 0 && !out_valid) break;
        end
        check("drain_empty", exp_q.size() + int'(out_valid), 0);
        @(posedge clk); #1;
    endtask

    function automatic int rnd_sample();
        return int'($urandom_range(0, 4095)) - 2048;
    endfunction

    typedef struct {bit ready; int m; int n; int pair;} vec_t;
    vec_t tbl[13];
    bit   stim_done;

    initial begin
        int k;
        int base;
        // Ramp + backpressure vectors: pairs in bit-reversed order, pair 2 stalled five cycles.
        k = 0;
        for (int p = 0; p < 8; p++) begin
            if (p == 2) begin
                for (int h = 0; h < 5; h++) begin
                    tbl[k] = '{1'b0, pair_src[p] - RAMP_MEAN, pair_src[p] + 8 - RAMP_MEAN, p};
                    k++;
                end
            end
            tbl[k] = '{1'b1, pair_src[p] - RAMP_MEAN, pair_src[p] + 8 - RAMP_MEAN, p};
            k++;
        end

        // Reset state
        rst = 1'b1; in_valid = 1'b0; in_sample = '0; out_ready = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_in_ready", int'(in_ready), 1);
        check("rst_out_valid", int'(out_valid), 0);
        check("rst_out_last", int'(out_last), 0);
        check("rst_out_pair", int'(out_pair), 0);
        check("rst_out_data", int'(out_m_real) | int'(out_n_real), 0);
        @(posedge clk); #1;
        rst = 1'b0;

        // Ramp order, first-output latency, then the vector table with a stall on pair 2
        out_ready = 1'b1;
        for (int i = 0; i < 16; i++) send(i);
        @(negedge clk);
        check("latency_not_yet", int'(out_valid), 0);
        @(posedge clk); #1;
        foreach (tbl[i]) begin
            out_ready = tbl[i].ready;
            @(negedge clk);
            check("tbl_valid", int'(out_valid), 1);
            check("tbl_m", int'(out_m_real), tbl[i].m);
            check("tbl_n", int'(out_n_real), tbl[i].n);
            check("tbl_pair", int'(out_pair), tbl[i].pair);
            check("tbl_last", int'(out_last), int'(tbl[i].pair == 7));
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        wait_drain();

        // Both banks full, then release
        out_ready = 1'b0;
        for (int i = 0; i < 32; i++) send(rnd_sample());
        @(negedge clk);
        check("full_in_ready", int'(in_ready), 0);
        check("full_pair0_waiting", int'(out_valid) * 16 + int'(out_pair), 16);
        @(posedge clk); #1;
        out_ready = 1'b1;
        for (int c = 1; c < 16; c++) begin
            @(posedge clk);
            @(negedge clk);
            if (c <= 7) check("release_in_ready", int'(in_ready), int'(c == 7));
            check("release_no_gap", int'(out_valid) * 16 + int'(out_pair), 16 + (c % 8));
        end
        wait_drain();

        // Reset mid-frame
        for (int i = 0; i < 7; i++) send(rnd_sample());
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        base = pairs_seen;
        for (int i = 0; i < 16; i++) send(100);
        wait_drain();
        check("rst_mid_pairs", pairs_seen - base, 8);
        check("rst_mid_value", last_m * 10000 + last_n, adjust(100, 100 - RAMP_MEAN * 0 - 0) * 10001);

        // Continuous streaming, 3 frames
        base = pairs_seen;
        for (int i = 0; i < 48; i++) send(rnd_sample());
        wait_drain();
        check("stream_pairs", pairs_seen - base, 24);

`ifdef FFT_IN_DC_REMOVE_EN
        for (int i = 0; i < 16; i++) send(500);
        wait_drain();
        check("dc_flat_zero", last_m * 10000 + last_n, 0);
        for (int i = 0; i < 16; i++) send((i % 2 == 0) ? 2047 : -2048);
        wait_drain();
        check("dc_alt_neg", last_m, -2047);
        check("dc_alt_neg_n", last_n, -2047);
`endif

        // Randomized traffic: idle gaps on input, random backpressure on output
        stim_done = 1'b0;
        fork
            begin
                for (int i = 0; i < 96; i++) begin
                    repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
                    send(rnd_sample());
                end
                stim_done = 1'b1;
            end
            begin
                for (int g = 0; g < 3000; g++) begin
                    @(posedge clk); #1;
                    out_ready = ($urandom_range(0, 2) != 0);
                    if (stim_done && exp_q.size() == 0 && !out_valid) break;
                end
            end
        join
        out_ready = 1'b1;
        wait_drain();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
